seq_mul_writeback: RTL and testbench



---
 rtl/proc_defs.sv | 15 +
 rtl/mul_shift_add_dp.sv | 60 ++++++
 rtl/seq_mul_writeback.sv | 130 +++++++++++++
 tb/tb_seq_mul_writeback.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/proc_defs.sv
// Definitions shared by the MUL execute/writeback path, the register file and the control unit.
package proc_defs;

    localparam int REG_W      = 8;
    localparam int REG_ADDR_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } mul_state_e;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiplier datapath: accumulator, multiplier shift register, adder and bit counter.
// After WIDTH steps {acc, mplr} holds the full unsigned product.
module mul_shift_add_dp #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   mplr_i,
    output logic               last_step_o,
    output logic [2*WIDTH-1:0] prod_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   sum;

    // The adder carry becomes the top bit of the accumulator as {carry, acc, mplr} shifts right.
    always_comb begin
        sum     = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : {(WIDTH + 1){1'b0}});
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        if (init_i) begin
            acc_d   = '0;
            mplr_d  = mplr_i;
            mcand_d = mcand_i;
            cnt_d   = '0;
        end else if (step_i) begin
            acc_d  = sum[WIDTH:1];
            mplr_d = {sum[0], mplr_q[WIDTH-1:1]};
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            mplr_q  <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
        end
    end

    assign last_step_o = (cnt_q == CNT_W'(WIDTH));
    assign prod_o      = {acc_q, mplr_q};

endmodule

// File: rtl/seq_mul_writeback.sv
// MUL execute + writeback: sequential shift-add multiply, then the product is written into
// the register file (low half to rd, optionally high half to rd+1). All outputs are registered.
module seq_mul_writeback
    import proc_defs::*;
#(
    parameter int WIDTH   = REG_W,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter bit WB_HIGH = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [ADDR_W-1:0]  rd,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [ADDR_W-1:0]  rf_address,
    output logic               rf_load,
    output logic [WIDTH-1:0]   rf_d_in
);

    mul_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  rd_q, rd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [ADDR_W-1:0]  rf_addr_q, rf_addr_d;
    logic               rf_load_q, rf_load_d;
    logic [WIDTH-1:0]   rf_data_q, rf_data_d;

    logic               dp_init;
    logic               dp_step;
    logic               dp_last;
    logic [2*WIDTH-1:0] dp_prod;

    mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk        (clk),
        .reset      (reset),
        .init_i     (dp_init),
        .step_i     (dp_step),
        .mcand_i    (op_a),
        .mplr_i     (op_b),
        .last_step_o(dp_last),
        .prod_o     (dp_prod)
    );

    // CALC keeps stepping until the counter reports WIDTH completed iterations.
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        dp_init = 1'b0;
        dp_step = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dp_init = 1'b1;
                    rd_d    = rd;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (dp_last) begin
                    state_d = S_WR_LO;
                end else begin
                    dp_step = 1'b1;
                end
            end
            S_WR_LO: state_d = WB_HIGH ? S_WR_HI : S_DONE;
            S_WR_HI: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they line up with it in the same cycle.
    always_comb begin
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        rf_load_d = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        product_d = product_q;
        case (state_d)
            S_WR_LO: begin
                rf_load_d = 1'b1;
                rf_addr_d = rd_q;
                rf_data_d = dp_prod[WIDTH-1:0];
            end
            S_WR_HI: begin
                rf_load_d = 1'b1;
                rf_addr_d = rd_q + ADDR_W'(1);
                rf_data_d = dp_prod[2*WIDTH-1:WIDTH];
            end
            S_DONE:  product_d = dp_prod;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rd_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            rf_addr_q <= '0;
            rf_load_q <= 1'b0;
            rf_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
            rf_addr_q <= rf_addr_d;
            rf_load_q <= rf_load_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign product    = product_q;
    assign rf_address = rf_addr_q;
    assign rf_load    = rf_load_q;
    assign rf_d_in    = rf_data_q;

endmodule

// File: tb/tb_seq_mul_writeback.sv
// Self-checking bench for seq_mul_writeback: one instance with high-half writeback, one without.
module tb_seq_mul_writeback;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        startB;
    logic [7:0]  opA;
    logic [7:0]  opB;
    logic [2:0]  rdIn;

    logic        busyA, doneA, rfLoadA;
    logic [15:0] productA;
    logic [2:0]  rfAddrA;
    logic [7:0]  rfDataA;
    logic        busyB, doneB, rfLoadB;
    logic [15:0] productB;
    logic [2:0]  rfAddrB;
    logic [7:0]  rfDataB;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  rd;
        bit          useB;
        bit          disturb;
        logic [15:0] expProd;
    } vec_t;

    vec_t vecs[$];

    seq_mul_writeback #(.WIDTH(8), .ADDR_W(3), .WB_HIGH(1'b1)) dutA (
        .clk(clk), .reset(reset), .start(start), .op_a(opA), .op_b(opB), .rd(rdIn),
        .busy(busyA), .done(doneA), .product(productA),
        .rf_address(rfAddrA), .rf_load(rfLoadA), .rf_d_in(rfDataA)
    );

    seq_mul_writeback #(.WIDTH(8), .ADDR_W(3), .WB_HIGH(1'b0)) dutB (
        .clk(clk), .reset(reset), .start(startB), .op_a(opA), .op_b(opB), .rd(rdIn),
        .busy(busyB), .done(doneB), .product(productB),
        .rf_address(rfAddrB), .rf_load(rfLoadB), .rf_d_in(rfDataB)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] modelProduct(input logic [7:0] a, input logic [7:0] b);
        return 16'(a) * 16'(b);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic [7:0] a, input logic [7:0] b, input logic [2:0] rd,
                          input bit useB, input bit disturb, input logic [15:0] expProd);
        vec_t v;
        v.a = a; v.b = b; v.rd = rd; v.useB = useB; v.disturb = disturb; v.expProd = expProd;
        vecs.push_back(v);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".busyA"},    32'(busyA),    32'd0);
        checkOutput({tag, ".doneA"},    32'(doneA),    32'd0);
        checkOutput({tag, ".rfLoadA"},  32'(rfLoadA),  32'd0);
        checkOutput({tag, ".productA"}, 32'(productA), 32'd0);
        checkOutput({tag, ".rfAddrA"},  32'(rfAddrA),  32'd0);
        checkOutput({tag, ".rfDataA"},  32'(rfDataA),  32'd0);
        checkOutput({tag, ".busyB"},    32'(busyB),    32'd0);
        checkOutput({tag, ".rfLoadB"},  32'(rfLoadB),  32'd0);
        checkOutput({tag, ".productB"}, 32'(productB), 32'd0);
    endtask

    // One full operation from the start edge (cycle 0), observed for a fixed window of cycles.
    task automatic applyStimulus(input vec_t v, input string tag);
        logic [2:0]  hiAddr;
        int          expDone, expWrites, doneCycle, donePulses, nW, busyErrs;
        logic [2:0]  wAddr[4];
        logic [7:0]  wData[4];
        int          wCyc[4];
        logic        smpBusy, smpDone, smpLoad;
        logic [2:0]  smpAddr;
        logic [7:0]  smpData;
        logic [15:0] smpProd;

        hiAddr     = 3'((int'(v.rd) + 1) % 8);
        expDone    = v.useB ? W + 2 : W + 3;
        expWrites  = v.useB ? 1 : 2;
        doneCycle  = -1;
        donePulses = 0;
        nW         = 0;
        busyErrs   = 0;
        for (int k = 0; k < 4; k++) begin
            wAddr[k] = '1; wData[k] = '1; wCyc[k] = -1;
        end

        opA = v.a; opB = v.b; rdIn = v.rd;
        if (v.useB) startB = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; startB = 1'b0;
        opA = ~v.a; opB = v.b ^ 8'h5A; rdIn = ~v.rd;
        smpBusy = v.useB ? busyB : busyA;
        if (smpBusy !== 1'b1) busyErrs++;

        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0; startB = 1'b0;
            smpBusy = v.useB ? busyB   : busyA;
            smpDone = v.useB ? doneB   : doneA;
            smpLoad = v.useB ? rfLoadB : rfLoadA;
            smpAddr = v.useB ? rfAddrB : rfAddrA;
            smpData = v.useB ? rfDataB : rfDataA;
            if (smpBusy !== ((cyc <= expDone) ? 1'b1 : 1'b0)) busyErrs++;
            if (smpLoad === 1'b1) begin
                if (nW < 4) begin
                    wAddr[nW] = smpAddr; wData[nW] = smpData; wCyc[nW] = cyc;
                end
                nW++;
            end
            if (smpDone === 1'b1) begin
                if (doneCycle < 0) doneCycle = cyc;
                donePulses++;
            end
            if (v.disturb && (cyc == 4 || cyc == expDone)) begin
                opA = 8'd1; opB = 8'd1; rdIn = 3'd0;
                if (v.useB) startB = 1'b1; else start = 1'b1;
            end
        end

        smpProd = v.useB ? productB : productA;
        smpAddr = v.useB ? rfAddrB  : rfAddrA;
        smpData = v.useB ? rfDataB  : rfDataA;
        checkOutput({tag, ".done_cycle"},  32'(doneCycle),  32'(expDone));
        checkOutput({tag, ".done_pulses"}, 32'(donePulses), 32'd1);
        checkOutput({tag, ".writes"},      32'(nW),         32'(expWrites));
        checkOutput({tag, ".lo_addr"},     32'(wAddr[0]),   32'(v.rd));
        checkOutput({tag, ".lo_data"},     32'(wData[0]),   32'(v.expProd[7:0]));
        checkOutput({tag, ".lo_cycle"},    32'(wCyc[0]),    32'(W + 1));
        if (!v.useB) begin
            checkOutput({tag, ".hi_addr"},  32'(wAddr[1]), 32'(hiAddr));
            checkOutput({tag, ".hi_data"},  32'(wData[1]), 32'(v.expProd[15:8]));
            checkOutput({tag, ".hi_cycle"}, 32'(wCyc[1]),  32'(W + 2));
        end
        checkOutput({tag, ".product"},   32'(smpProd),  32'(v.expProd));
        checkOutput({tag, ".busy_errs"}, 32'(busyErrs), 32'd0);
        checkOutput({tag, ".hold_addr"}, 32'(smpAddr),  v.useB ? 32'(v.rd) : 32'(hiAddr));
        checkOutput({tag, ".hold_data"}, 32'(smpData),  v.useB ? 32'(v.expProd[7:0]) : 32'(v.expProd[15:8]));
    endtask

    initial begin
        int loads;
        logic [7:0] ra, rb;
        logic [2:0] rr;

        reset = 1'b1; start = 1'b0; startB = 1'b0;
        opA = '0; opB = '0; rdIn = '0;
        #12;
        checkResetState("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        opA = 8'd200; opB = 8'd100; rdIn = 3'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        #2;
        reset = 1'b1;
        #1;
        checkResetState("midreset");
        loads = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (rfLoadA !== 1'b0) loads++;
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (rfLoadA !== 1'b0 || busyA !== 1'b0 || doneA !== 1'b0) loads++;
        end
        checkOutput("midreset.no_activity", 32'(loads), 32'd0);

        addVec(8'd3,   8'd5,   3'd1, 1'b0, 1'b0, 16'h000F);
        addVec(8'd13,  8'd11,  3'd2, 1'b0, 1'b0, 16'h008F);
        addVec(8'd255, 8'd255, 3'd7, 1'b0, 1'b0, 16'hFE01);
        addVec(8'd0,   8'd200, 3'd4, 1'b0, 1'b0, 16'h0000);
        addVec(8'd6,   8'd7,   3'd5, 1'b0, 1'b1, 16'h002A);
        addVec(8'd16,  8'd16,  3'd6, 1'b1, 1'b0, 16'h0100);
        addVec(8'd255, 8'd255, 3'd7, 1'b1, 1'b1, 16'hFE01);
        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rr = 3'($urandom_range(0, 7));
            addVec(ra, rb, rr, (i >= 6), (i % 3 == 0), modelProduct(ra, rb));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], $sformatf("v%0d_%0dx%0d_rd%0d%s", i, vecs[i].a, vecs[i].b,
                                             vecs[i].rd, vecs[i].useB ? "_lo" : ""));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
